// File: rtl/gpio_sweep_ctrl.sv
// gpio_sweep_ctrl: one-hot sweep sequencer for the breakout GPIO pads.
// Walks a programmable pin window with a programmable dwell time and pass count.
// It has start/stop/pause control and reports busy, done and a sticky config-error flag.
// Optional macro BOUNCE_MODE_EN adds a `bounce` input that makes each pass
// ping-pong first->last->first instead of ascending only.
module gpio_sweep_ctrl #(
    parameter int NUM_PINS      = 34,
    parameter int CYCLES_PER_MS = 10000,
    parameter int CNT_W         = 28
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic [13:0]         prescaler,
    input  logic [5:0]          first_pin,
    input  logic [5:0]          last_pin,
    input  logic [7:0]          repeat_cnt,
`ifdef BOUNCE_MODE_EN
    input  logic                bounce,
`endif
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oeb,
    output logic                done,
    output logic                busy,
    output logic                cfg_err,
    output logic [5:0]          cur_pin
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_term, w_term_nxt;
    logic [5:0]       r_pin, w_pin_nxt;
    logic [5:0]       r_first, w_first_nxt;
    logic [5:0]       r_last, w_last_nxt;
    logic [7:0]       r_passes, w_passes_nxt;
    logic             r_cfg_err, w_cfg_err_nxt;
    logic             r_bounce, w_bounce_nxt;
    logic             r_down, w_down_nxt;

    logic             w_bounce_in;
    logic             w_start_ok;
    logic             w_tick;
    logic             w_pass_end;
    logic [CNT_W-1:0] w_dwell;

`ifdef BOUNCE_MODE_EN
    assign w_bounce_in = bounce;
`else
    assign w_bounce_in = 1'b0;
`endif

    // Dwell length in cycles, formed at counter width; the latched value is
    // the terminal count (length - 1).
    assign w_dwell    = CNT_W'(prescaler) * CNT_W'(CYCLES_PER_MS);
    assign w_start_ok = (prescaler != 14'd0) && (first_pin <= last_pin) &&
                        (last_pin <= 6'(NUM_PINS - 1));
    assign w_tick     = (r_cnt == r_term);

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_term    <= '0;
            r_pin     <= '0;
            r_first   <= '0;
            r_last    <= '0;
            r_passes  <= '0;
            r_cfg_err <= 1'b0;
            r_bounce  <= 1'b0;
            r_down    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_term    <= w_term_nxt;
            r_pin     <= w_pin_nxt;
            r_first   <= w_first_nxt;
            r_last    <= w_last_nxt;
            r_passes  <= w_passes_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_bounce  <= w_bounce_nxt;
            r_down    <= w_down_nxt;
        end
    end

    // Next-state logic; priority is en low, then stop, then pause, then the dwell tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_term_nxt    = r_term;
        w_pin_nxt     = r_pin;
        w_first_nxt   = r_first;
        w_last_nxt    = r_last;
        w_passes_nxt  = r_passes;
        w_cfg_err_nxt = r_cfg_err;
        w_bounce_nxt  = r_bounce;
        w_down_nxt    = r_down;
        w_pass_end    = 1'b0;

        if (!en || stop) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_pin_nxt    = '0;
            w_passes_nxt = '0;
            w_down_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            w_state_nxt   = S_RUN;
                            w_term_nxt    = w_dwell - CNT_W'(1);
                            w_first_nxt   = first_pin;
                            w_last_nxt    = last_pin;
                            w_pin_nxt     = first_pin;
                            w_passes_nxt  = repeat_cnt;
                            w_bounce_nxt  = w_bounce_in;
                            w_down_nxt    = 1'b0;
                            w_cnt_nxt     = '0;
                            w_cfg_err_nxt = 1'b0;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (pause) begin
                        // Freeze everything, including a pending tick at the terminal count.
                        w_state_nxt = S_PAUSE;
                    end else begin
                        // The cycle in which pause is released already runs as a dwell cycle.
                        w_state_nxt = S_RUN;
                        if (w_tick) begin
                            w_cnt_nxt = '0;
                            if (r_down) begin
                                if (r_pin != r_first) w_pin_nxt = r_pin - 6'd1;
                                else                  w_pass_end = 1'b1;
                            end else if (r_pin != r_last) begin
                                w_pin_nxt = r_pin + 6'd1;
                            end else if (r_bounce && (r_first != r_last)) begin
                                // Turn around without repeating the top pin.
                                w_down_nxt = 1'b1;
                                w_pin_nxt  = r_pin - 6'd1;
                            end else begin
                                w_pass_end = 1'b1;
                            end
                            if (w_pass_end) begin
                                w_down_nxt = 1'b0;
                                if (r_passes != 8'd0) begin
                                    w_passes_nxt = r_passes - 8'd1;
                                    w_pin_nxt    = r_first;
                                end else begin
                                    w_state_nxt = S_DONE;
                                end
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Start in this cycle is dropped on purpose.
                    w_state_nxt  = S_IDLE;
                    w_pin_nxt    = '0;
                    w_passes_nxt = '0;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Pad and status outputs, combinational from registered state.
    assign busy     = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign done     = en && (r_state == S_DONE);
    assign cfg_err  = r_cfg_err;
    assign cur_pin  = r_pin;
    assign gpio_oeb = en ? '0 : '1;
    assign gpio_out = (en && busy) ? (NUM_PINS'(1) << r_pin) : '0;

endmodule

// File: tb/tb_gpio_sweep_ctrl.sv
// Directed bench for gpio_sweep_ctrl with CYCLES_PER_MS=4.
// Stimulus pushes the hand-derived expected outputs for every cycle into a
// queue, and a monitor pops and compares them each cycle.
module tb_gpio_sweep_ctrl;

    logic        clk = 1'b0;
    logic        nrst, en, start, stop, pause;
    logic [13:0] prescaler;
    logic [5:0]  first_pin, last_pin;
    logic [7:0]  repeat_cnt;
`ifdef BOUNCE_MODE_EN
    logic        bounce;
`endif
    logic [33:0] gpio_out, gpio_oeb;
    logic        done, busy, cfg_err;
    logic [5:0]  cur_pin;

    typedef struct {
        string       nm;
        logic [33:0] out;
        logic        oeb1;
        logic        dn;
        logic        bz;
        logic        ce;
        int          pin;   // -1: not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    event chk_ev;

    gpio_sweep_ctrl #(.NUM_PINS(34), .CYCLES_PER_MS(4), .CNT_W(28)) dut (
        .clk(clk), .nrst(nrst), .en(en), .start(start), .stop(stop), .pause(pause),
        .prescaler(prescaler), .first_pin(first_pin), .last_pin(last_pin),
        .repeat_cnt(repeat_cnt),
`ifdef BOUNCE_MODE_EN
        .bounce(bounce),
`endif
        .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .done(done), .busy(busy),
        .cfg_err(cfg_err), .cur_pin(cur_pin)
    );

    always #5 clk = ~clk;

    // Monitor: compare one expected record per cycle, or on demand for async checks.
    always @(negedge clk or chk_ev) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            n_tests++;
            if (gpio_out !== m_e.out || gpio_oeb !== {34{m_e.oeb1}} || done !== m_e.dn ||
                busy !== m_e.bz || cfg_err !== m_e.ce ||
                (m_e.pin >= 0 && cur_pin !== 6'(m_e.pin))) begin
                n_fail++;
                $display("FAIL %s: got out=%h oeb=%h done=%b busy=%b cfg_err=%b pin=%0d; want out=%h oeb_all=%b done=%b busy=%b cfg_err=%b pin=%0d",
                         m_e.nm, gpio_out, gpio_oeb, done, busy, cfg_err, cur_pin,
                         m_e.out, m_e.oeb1, m_e.dn, m_e.bz, m_e.ce, m_e.pin);
            end
        end
    end

    function automatic logic [33:0] hot(input int p);
        logic [33:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic exp_t mk(input string nm, input logic [33:0] out, input logic dn,
                                input logic bz, input logic ce, input int pin);
        exp_t e;
        e.nm = nm; e.out = out; e.oeb1 = ~en; e.dn = dn; e.bz = bz; e.ce = ce; e.pin = pin;
        return e;
    endfunction

    // Advance one clock, queue the expectation for the new cycle, return after the check.
    task automatic step(input string nm, input logic [33:0] out, input logic dn,
                        input logic bz, input logic ce, input int pin);
        @(posedge clk); #1;
        exp_q.push_back(mk(nm, out, dn, bz, ce, pin));
        @(negedge clk); #1;
    endtask

    task automatic hold(input string nm, input int pin, input int n);
        repeat (n) step(nm, hot(pin), 1'b0, 1'b1, 1'b0, pin);
    endtask

    task automatic idle(input string nm, input logic ce);
        step(nm, '0, 1'b0, 1'b0, ce, 0);
    endtask

    task automatic done_cyc(input string nm);
        step(nm, '0, 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic cfg(input int ps, input int f, input int l, input int r);
        prescaler  = 14'(ps);
        first_pin  = 6'(f);
        last_pin   = 6'(l);
        repeat_cnt = 8'(r);
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg(1, 0, 2, 0);
`ifdef BOUNCE_MODE_EN
        bounce = 1'b0;
`endif
        #3;
        exp_q.push_back(mk("reset", '0, 1'b0, 1'b0, 1'b0, 0));
        -> chk_ev;
        #1;
        @(negedge clk); #1;
        nrst = 1'b1; en = 1'b1;
        idle("idle_after_reset", 1'b0);

        // Basic ascending sweep 0..2, one pass.
        cfg(1, 0, 2, 0); start = 1'b1;
        hold("t1_pin0", 0, 1); start = 1'b0;
        hold("t1_pin0", 0, 3);
        hold("t1_pin1", 1, 4);
        hold("t1_pin2", 2, 4);
        done_cyc("t1_done");
        idle("t1_idle", 1'b0);

        // Single-pin window at the top pin, two passes of 8 cycles.
        cfg(2, 33, 33, 1); start = 1'b1;
        hold("t2_pin33", 33, 1); start = 1'b0;
        hold("t2_pin33", 33, 15);
        done_cyc("t2_done");
        idle("t2_idle", 1'b0);

        // Rejected starts set cfg_err; a valid start clears it.
        cfg(0, 0, 2, 0); start = 1'b1;
        idle("t3_presc0", 1'b1); start = 1'b0;
        idle("t3_sticky", 1'b1);
        cfg(1, 5, 5, 0); start = 1'b1;
        hold("t3_clear1", 5, 1); start = 1'b0; stop = 1'b1;
        idle("t3_stop1", 1'b0); stop = 1'b0;
        cfg(1, 5, 3, 0); start = 1'b1;
        idle("t3_first_gt_last", 1'b1); start = 1'b0;
        cfg(1, 5, 5, 0); start = 1'b1;
        hold("t3_clear2", 5, 1); start = 1'b0; stop = 1'b1;
        idle("t3_stop2", 1'b0); stop = 1'b0;
        cfg(1, 0, 40, 0); start = 1'b1;
        idle("t3_last40", 1'b1); start = 1'b0;
        cfg(1, 0, 33, 0); start = 1'b1;
        hold("t3_clear3", 0, 1); start = 1'b0; stop = 1'b1;
        idle("t3_stop3", 1'b0); stop = 1'b0;

        // Pause in IDLE does nothing.
        pause = 1'b1;
        idle("t4_pause_idle", 1'b0); pause = 1'b0;

        // Pause mid pin1 and at the pin2 terminal count; mid-run config/start ignored.
        cfg(1, 0, 2, 0); start = 1'b1;
        hold("t4_pin0", 0, 1); start = 1'b0;
        cfg(0, 0, 40, 0); start = 1'b1;
        hold("t4_busy_start", 0, 1); start = 1'b0;
        hold("t4_pin0", 0, 2);
        hold("t4_pin1_run", 1, 3); pause = 1'b1;
        hold("t4_pin1_pause", 1, 10); pause = 1'b0;
        hold("t4_pin1_resume", 1, 1);
        hold("t4_pin2", 2, 4); pause = 1'b1;
        hold("t4_pin2_tickpause", 2, 2); pause = 1'b0;
        done_cyc("t4_done");
        idle("t4_idle", 1'b0);

        // Stop mid pin1: straight to idle, no done.
        cfg(1, 0, 2, 0); start = 1'b1;
        hold("t5_pin0", 0, 1); start = 1'b0;
        hold("t5_pin0", 0, 3);
        hold("t5_pin1", 1, 2); stop = 1'b1;
        idle("t5_stop", 1'b0); stop = 1'b0;
        idle("t5_stop_idle", 1'b0);

        // en low mid-run: outputs off, pads tri-stated, no done.
        start = 1'b1;
        hold("t6_pin0", 0, 1); start = 1'b0;
        hold("t6_pin0", 0, 1); en = 1'b0;
        idle("t6_en0", 1'b0);
        idle("t6_en0_hold", 1'b0); en = 1'b1;
        idle("t6_en1", 1'b0);

        // Async reset mid-run clears outputs before the next clock edge.
        start = 1'b1;
        hold("t7_pin0", 0, 1); start = 1'b0;
        hold("t7_pin0", 0, 1);
        nrst = 1'b0; #2;
        exp_q.push_back(mk("t7_async_rst", '0, 1'b0, 1'b0, 1'b0, 0));
        -> chk_ev;
        #1;
        @(negedge clk); #1;
        idle("t7_rst_held", 1'b0); nrst = 1'b1;
        idle("t7_rst_rel", 1'b0);

`ifdef BOUNCE_MODE_EN
        // Ping-pong pass 0,1,2,1,0.
        cfg(1, 0, 2, 0); bounce = 1'b1; start = 1'b1;
        hold("t8_b0", 0, 1); start = 1'b0; bounce = 1'b0;
        hold("t8_b0", 0, 3);
        hold("t8_b1", 1, 4);
        hold("t8_b2", 2, 4);
        hold("t8_b1_dn", 1, 4);
        hold("t8_b0_dn", 0, 4);
        done_cyc("t8_done");
        idle("t8_idle", 1'b0);
`endif

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
